// File: rtl/ulpi_cmd_tx_if.sv
// ulpi_cmd_tx_if: ULPI link pins plus the requester handshake of the TX command engine
interface ulpi_cmd_tx_if;
    logic       ulpi_dir;
    logic       ulpi_nxt;
    logic       ulpi_stp;
    logic [7:0] ulpi_data_o;
    logic       ulpi_data_oe;
    logic       phy_write_i;
    logic       phy_nopid_i;
    logic       phy_stop_i;
    logic [7:0] phy_addr_i;
    logic [7:0] phy_data_i;
    logic       phy_busy_o;
    logic       phy_done_o;
    logic       phy_error_o;
    logic [2:0] tx_state_o;
    modport master (
        input  ulpi_dir, ulpi_nxt, phy_write_i, phy_nopid_i, phy_stop_i, phy_addr_i, phy_data_i,
        output ulpi_stp, ulpi_data_o, ulpi_data_oe, phy_busy_o, phy_done_o, phy_error_o, tx_state_o
    );
    modport slave (
        output ulpi_dir, ulpi_nxt, phy_write_i, phy_nopid_i, phy_stop_i, phy_addr_i, phy_data_i,
        input  ulpi_stp, ulpi_data_o, ulpi_data_oe, phy_busy_o, phy_done_o, phy_error_o, tx_state_o
    );
endinterface

// File: rtl/ulpi_cmd_tx.sv
// ulpi_cmd_tx: link-side ULPI transmit-command engine for register writes and NOPID/stop
module ulpi_cmd_tx #(
    parameter int NXT_TIMEOUT = 63,
    parameter int MAX_RETRY   = 3
) (
    input logic           clock,
    input logic           reset_n,
    ulpi_cmd_tx_if.master bus
);
    localparam int RW = $clog2(MAX_RETRY + 2);
    typedef enum logic [2:0] {IDLE, WR_CMD, WR_DAT, WR_STP, WAIT_BUS, NP_CMD, NP_DAT, NP_STP} state_t;
    state_t state, state_nx;
    logic dir_q, own, stop_pend, done_nx, error_nx, tmo_hit, counting, last_try;
    logic [1:0] hold;
    logic [5:0] tmo;
    logic [RW-1:0] retry;
    logic [7:0] addr_q, data_q, addr_nx, data_nx, byte_nx;
    // the turnaround cycle after dir falls still belongs to the PHY
    assign own = !bus.ulpi_dir && !dir_q;
    assign counting = state == WR_CMD || state == WR_DAT || state == NP_CMD;
    assign tmo_hit = counting && !bus.ulpi_nxt && tmo == 6'(NXT_TIMEOUT - 1);
    assign last_try = retry == RW'(MAX_RETRY);
    assign addr_nx = state == IDLE ? bus.phy_addr_i : addr_q;
    assign data_nx = state == IDLE ? bus.phy_data_i : data_q;
    assign byte_nx = state_nx == WR_CMD ? addr_nx : state_nx == WR_DAT ? data_nx :
                     state_nx == NP_CMD ? 8'h40 : 8'h00;
    assign bus.tx_state_o = state;
    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        error_nx = 1'b0;
        case (state)
            IDLE: if (own && hold == 2'd0)
                state_nx = bus.phy_write_i ? WR_CMD : bus.phy_nopid_i ? NP_CMD : IDLE;
            WR_CMD, WR_DAT: begin
                if (bus.ulpi_dir) begin
                    state_nx = last_try ? IDLE : WAIT_BUS;
                    done_nx  = last_try;
                    error_nx = last_try;
                end else if (bus.ulpi_nxt) begin
                    state_nx = state == WR_CMD ? WR_DAT : WR_STP;
                end else if (tmo_hit) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    error_nx = 1'b1;
                end
            end
            WR_STP: begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
            WAIT_BUS: if (own) state_nx = WR_CMD;
            NP_CMD: begin
                if (bus.ulpi_dir || tmo_hit) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    error_nx = 1'b1;
                end else if (bus.ulpi_nxt) begin
                    state_nx = NP_DAT;
                    done_nx  = 1'b1;
                end
            end
            // 0x40 already accepted: abort reports error without a second done
            NP_DAT: begin
                if (bus.ulpi_dir) begin
                    state_nx = IDLE;
                    error_nx = 1'b1;
                end else if (bus.phy_stop_i || stop_pend) begin
                    state_nx = NP_STP;
                end
            end
            NP_STP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            dir_q            <= 1'b0;
            addr_q           <= 8'h00;
            data_q           <= 8'h00;
            retry            <= '0;
            tmo              <= 6'd0;
            stop_pend        <= 1'b0;
            hold             <= 2'd0;
            bus.ulpi_stp     <= 1'b0;
            bus.ulpi_data_o  <= 8'h00;
            bus.ulpi_data_oe <= 1'b0;
            bus.phy_busy_o   <= 1'b0;
            bus.phy_done_o   <= 1'b0;
            bus.phy_error_o  <= 1'b0;
        end else begin
            state            <= state_nx;
            dir_q            <= bus.ulpi_dir;
            addr_q           <= addr_nx;
            data_q           <= data_nx;
            retry            <= state == IDLE ? '0 :
                                state_nx == WAIT_BUS && state != WAIT_BUS ? retry + 1'b1 : retry;
            tmo              <= state_nx != state ? 6'd0 : counting && !bus.ulpi_nxt ? tmo + 6'd1 : tmo;
            stop_pend        <= state == NP_CMD && (stop_pend || bus.phy_stop_i);
            hold             <= done_nx ? 2'd2 : hold - {1'b0, hold != 2'd0};
            bus.ulpi_stp     <= state_nx == WR_STP || state_nx == NP_STP;
            bus.ulpi_data_o  <= byte_nx;
            bus.ulpi_data_oe <= own;
            bus.phy_busy_o   <= state_nx != IDLE;
            bus.phy_done_o   <= done_nx;
            bus.phy_error_o  <= error_nx;
        end
    end
endmodule
